event_uart_tx: RTL and testbench

- Transmit end of the event path: takes filtered DVS events (x, y, t, polarity) on a valid/ready interface and buffers them in a small FIFO.
- Serialises each event as a parity-protected 10-bit UART-style frame on a single output pin.
- Sits downstream of the event filter stage; tx drives an off-chip link/logic analyser.

---
 rtl/event_uart_tx.sv | 136 +++++++++++++
 tb/tb_event_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_uart_tx.sv
// Buffers filtered DVS events in a small FIFO and serialises each one as a
// 10-bit even-parity UART frame (start, 8 data bits LSB first, stop) on tx.
module event_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             x,
    input  logic [1:0]             y,
    input  logic [1:0]             t,
    input  logic                   p,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             sent_cnt
);
    // state | meaning
    // IDLE  | line high, waiting for a buffered event
    // START | driving the start bit
    // DATA  | driving data bit bit_idx
    // STOP  | driving the stop bit; chains straight into the next frame if one is queued
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [7:0]  BIT_LOAD = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [7:0]    bit_cnt;
    logic [6:0]    raw;
    logic          push;
    logic          pop;
    logic          bit_done;

    assign raw      = {p, x, y, t};
    assign in_ready = (level != FULL);
    assign push     = in_valid && in_ready;
    assign bit_done = (bit_cnt == 8'd0);
    // The FSM consumes the head only when it is about to start a frame.
    assign pop      = (level != '0) && ((state == IDLE) || ((state == STOP) && bit_done));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {^raw, raw};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            sent_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= BIT_LOAD;
                        state   <= START;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        bit_cnt <= BIT_LOAD;
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        sent_cnt <= sent_cnt + 1'b1;
                        if (pop) begin
                            shreg   <= mem[rd_ptr];
                            tx      <= 1'b0;
                            bit_cnt <= BIT_LOAD;
                            state   <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_event_uart_tx.sv
// Scoreboard bench for event_uart_tx: one instance at 4 clks/bit, one at 1 clk/bit.
module tb_event_uart_tx;
    localparam int CPB0  = 4;
    localparam int CPB1  = 1;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid0 = 1'b0;
    logic       in_valid1 = 1'b0;
    logic [1:0] x = '0;
    logic [1:0] y = '0;
    logic [1:0] t = '0;
    logic       p = 1'b0;
    logic       in_ready0, in_ready1, tx0, tx1, busy0, busy1;
    logic [2:0] level0, level1;
    logic [7:0] sent_cnt0, sent_cnt1;

    int n_chk = 0;
    int n_pass = 0;
    int frames0 = 0;
    int frames1 = 0;
    int busy_cyc0 = 0;
    int exp_sent0 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    event_uart_tx #(.CLKS_PER_BIT(CPB0), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .x(x), .y(y), .t(t), .p(p), .tx(tx0), .busy(busy0), .level(level0),
        .sent_cnt(sent_cnt0));

    event_uart_tx #(.CLKS_PER_BIT(CPB1), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .x(x), .y(y), .t(t), .p(p), .tx(tx1), .busy(busy1), .level(level1),
        .sent_cnt(sent_cnt1));

    always #5 clk = ~clk;

    always @(posedge clk) busy_cyc0 <= busy_cyc0 + (busy0 ? 1 : 0);

    function automatic logic [7:0] ev_byte(input logic [1:0] xx, input logic [1:0] yy,
                                           input logic [1:0] tt, input logic pp);
        logic [6:0] r;
        r = {pp, xx, yy, tt};
        return {^r, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Receives one frame whose first start-bit cycle has just been sampled.
    task automatic rx_frame(input int w, input int cpb, output logic [7:0] data,
                            output bit aborted, output bit stable);
        logic b0, s;
        stable = 1'b1;
        aborted = 1'b0;
        data = '0;
        b0 = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < cpb; c++) begin
                if (b != 0 || c != 0) begin
                    @(posedge clk);
                    #1;
                end
                if (!rst_n) begin
                    aborted = 1'b1;
                    return;
                end
                s = (w != 0) ? tx1 : tx0;
                if (c == 0) b0 = s;
                else if (s !== b0) stable = 1'b0;
            end
            if (b == 0 && b0 !== 1'b0) stable = 1'b0;
            if (b >= 1 && b <= 8) data[b-1] = b0;
            if (b == 9 && b0 !== 1'b1) stable = 1'b0;
        end
    endtask

    initial begin : mon0
        logic [7:0] d;
        bit ab, st;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && tx0 === 1'b0) begin
                rx_frame(0, CPB0, d, ab, st);
                if (!ab) begin
                    frames0++;
                    chk("frame_shape0", st, 1);
                    chk("parity0", ^d, 0);
                    chk("q0_nonempty", q0.size() != 0, 1);
                    if (q0.size() != 0) chk("data0", d, q0.pop_front());
                end
            end
        end
    end

    initial begin : mon1
        logic [7:0] d;
        bit ab, st;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && tx1 === 1'b0) begin
                rx_frame(1, CPB1, d, ab, st);
                if (!ab) begin
                    frames1++;
                    chk("frame_shape1", st, 1);
                    chk("parity1", ^d, 0);
                    chk("q1_nonempty", q1.size() != 0, 1);
                    if (q1.size() != 0) chk("data1", d, q1.pop_front());
                end
            end
        end
    end

    task automatic send(input int w, input logic [1:0] xx, input logic [1:0] yy,
                        input logic [1:0] tt, input logic pp, output bit acc);
        @(negedge clk);
        x = xx; y = yy; t = tt; p = pp;
        if (w == 0) begin
            in_valid0 = 1'b1; in_valid1 = 1'b0; acc = in_ready0;
            if (acc) q0.push_back(ev_byte(xx, yy, tt, pp));
        end else begin
            in_valid1 = 1'b1; in_valid0 = 1'b0; acc = in_ready1;
            if (acc) q1.push_back(ev_byte(xx, yy, tt, pp));
        end
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input int w, input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (w == 0) done = !busy0 && (level0 == 3'd0);
            else        done = !busy1 && (level1 == 3'd0);
        end
        chk(tag, done, 1);
    endtask

    // Single event into an idle dut0, traced cycle by cycle against the expected frame.
    task automatic trace_frame(input logic [1:0] xx, input logic [1:0] yy, input logic [1:0] tt,
                               input logic pp, input logic [7:0] exp_byte, input string tag);
        logic [9:0] fr;
        bit acc;
        fr = {1'b1, exp_byte, 1'b0};
        send(0, xx, yy, tt, pp, acc);
        chk({tag, "_acc"}, acc, 1);
        drop();
        for (int i = 0; i < 10 * CPB0; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_tx"}, tx0, fr[i / CPB0]);
            if (i == 0) begin
                chk({tag, "_busy_first"}, busy0, 1);
                chk({tag, "_level_popped"}, level0, 0);
            end
        end
        chk({tag, "_busy_last"}, busy0, 1);
        @(posedge clk);
        #1;
        exp_sent0++;
        chk({tag, "_busy_end"}, busy0, 0);
        chk({tag, "_sent"}, sent_cnt0, exp_sent0);
    endtask

    initial begin : watchdog
        #150000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit acc;
        int b0, fr_snap, low_cnt, tries;
        logic [6:0] r;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx0", tx0, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_level0", level0, 0);
        chk("rst_sent0", sent_cnt0, 0);
        chk("rst_ready0", in_ready0, 1);
        chk("rst_tx1", tx1, 1);
        chk("rst_ready1", in_ready1, 1);
        @(negedge clk);
        rst_n = 1'b1;

        trace_frame(2'b10, 2'b01, 2'b11, 1'b1, 8'hE7, "single");
        trace_frame(2'b00, 2'b00, 2'b00, 1'b0, 8'h00, "zero");

        // Backpressure: 8 cycles of valid, only 5 fit (1 popped + 4 buffered).
        b0 = busy_cyc0;
        for (int i = 0; i < 8; i++) begin
            send(0, i[1:0], {1'b0, i[2]}, ~i[1:0], i[0], acc);
            chk("bp_acc", acc, (i < 5) ? 1 : 0);
        end
        drop();
        chk("bp_level_full", level0, 4);
        chk("bp_ready_full", in_ready0, 0);
        wait_idle(0, 400, "bp_drain");
        exp_sent0 += 5;
        chk("bp_busy_cycles", busy_cyc0 - b0, 200);
        chk("bp_sent", sent_cnt0, exp_sent0);
        chk("bp_q_empty", q0.size(), 0);

        // Push coinciding with the pop at the end of a STOP bit.
        send(0, 2'd1, 2'd2, 2'd3, 1'b0, acc);
        send(0, 2'd2, 2'd3, 2'd0, 1'b1, acc);
        send(0, 2'd3, 2'd0, 2'd1, 1'b0, acc);
        drop();
        repeat (38) @(posedge clk);
        #1;
        chk("pp_level_before", level0, 2);
        chk("pp_tx_stop", tx0, 1);
        send(0, 2'd0, 2'd1, 2'd2, 1'b1, acc);
        chk("pp_acc", acc, 1);
        #1;
        chk("pp_level_after", level0, 2);
        chk("pp_tx_start", tx0, 0);
        chk("pp_busy", busy0, 1);
        drop();
        wait_idle(0, 400, "pp_drain");
        exp_sent0 += 4;
        chk("pp_sent", sent_cnt0, exp_sent0);

        // Reset during data bit 3 with two events still buffered.
        send(0, 2'd3, 2'd3, 2'd3, 1'b1, acc);
        send(0, 2'd1, 2'd1, 2'd1, 1'b0, acc);
        send(0, 2'd2, 2'd2, 2'd2, 1'b1, acc);
        drop();
        repeat (15) @(posedge clk);
        #1;
        chk("mr_level_pre", level0, 2);
        chk("mr_busy_pre", busy0, 1);
        fr_snap = frames0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_tx", tx0, 1);
        chk("mr_level", level0, 0);
        chk("mr_busy", busy0, 0);
        chk("mr_sent", sent_cnt0, 0);
        chk("mr_ready", in_ready0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        exp_sent0 = 0;
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (tx0 !== 1'b1 || busy0 !== 1'b0) low_cnt++;
        end
        chk("mr_quiet", low_cnt, 0);
        chk("mr_no_frames", frames0, fr_snap);

        // 256 frames at one clk per bit: sent_cnt wraps back to 0.
        for (int i = 0; i < 255; i++) begin
            r = 7'($urandom);
            tries = 0;
            do begin
                send(1, r[5:4], r[3:2], r[1:0], r[6], acc);
                tries++;
            end while (!acc && tries < 50);
            chk("wrap_push", acc, 1);
        end
        drop();
        wait_idle(1, 4000, "wrap_drain255");
        chk("wrap_sent255", sent_cnt1, 255);
        chk("wrap_frames255", frames1, 255);
        send(1, 2'd1, 2'd0, 2'd1, 1'b1, acc);
        chk("wrap_last_acc", acc, 1);
        drop();
        wait_idle(1, 100, "wrap_drain256");
        chk("wrap_sent0", sent_cnt1, 0);
        chk("wrap_frames256", frames1, 256);
        chk("wrap_q_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
